io_uart_port: RTL and testbench

//  Memory-mapped IO responder on the CPU SYS bus (io_*); the CPU is the initiator, this block is the target.

---
 rtl/rcpu_io_pkg.sv | 27 ++
 rtl/io_uart_port_if.sv | 23 ++
 rtl/io_byte_fifo.sv | 49 ++++
 rtl/io_uart_port.sv | 237 +++++++++++++++++++++++
 tb/tb_io_uart_port.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/rcpu_io_pkg.sv
// Shared constants for the CPU SYS-bus IO blocks: register offsets, STATUS bit
// weights and the UART serializer/deserializer state encodings.
package rcpu_io_pkg;

  localparam logic [15:0] OFS_DATA    = 16'd0;
  localparam logic [15:0] OFS_STATUS  = 16'd1;
  localparam logic [15:0] OFS_BAUD    = 16'd2;
  localparam logic [15:0] OFS_SCRATCH = 16'd3;

  localparam logic [15:0] ST_TX_FULL  = 16'h0001;
  localparam logic [15:0] ST_TX_EMPTY = 16'h0002;
  localparam logic [15:0] ST_RX_EMPTY = 16'h0004;
  localparam logic [15:0] ST_RX_FULL  = 16'h0008;
  localparam logic [15:0] ST_RXOVR    = 16'h0010;
  localparam logic [15:0] ST_FRAMERR  = 16'h0020;
  localparam logic [15:0] ST_TXDROP   = 16'h0040;
  localparam logic [15:0] ST_TX_BUSY  = 16'h0080;

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;

  // A divisor below 2 would make the RX half-bit count zero.
  function automatic logic [15:0] clamp_baud(input logic [15:0] v);
    return (v < 16'd2) ? 16'd2 : v;
  endfunction

endpackage

// File: rtl/io_uart_port_if.sv
// SYS bus between the CPU (master) and an IO responder (slave), plus the
// responder's FSM state for observation.
// Handshake: each strobe is a single-cycle request with no backpressure; read
// data is registered and valid from the cycle after io_read_enable until the next read.
interface io_uart_port_if;
  logic                      io_read_enable;
  logic                      io_write_enable;
  logic [15:0]               io_address;
  logic [15:0]               io_write_data;
  logic [15:0]               io_read_data;
  rcpu_io_pkg::tx_state_e    dbg_tx_state;
  rcpu_io_pkg::rx_state_e    dbg_rx_state;

  modport master (
    output io_read_enable, io_write_enable, io_address, io_write_data,
    input  io_read_data, dbg_tx_state, dbg_rx_state
  );

  modport slave (
    input  io_read_enable, io_write_enable, io_address, io_write_data,
    output io_read_data, dbg_tx_state, dbg_rx_state
  );
endinterface

// File: rtl/io_byte_fifo.sv
// 8-bit synchronous FIFO; pointers carry one extra wrap bit so full and empty
// are distinguishable. A push into a full FIFO succeeds when a pop happens on the same edge.
module io_byte_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push_i,
  input  logic [7:0] data_i,
  input  logic       pop_i,
  output logic [7:0] data_o,
  output logic       full_o,
  output logic       empty_o
);
  localparam int AW = $clog2(DEPTH);

  logic [7:0]  mem_q [DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic        do_push, do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign data_o  = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
    if (do_pop)  rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
  end
endmodule

// File: rtl/io_uart_port.sv
// Memory-mapped UART responder: DATA/STATUS/BAUD/SCRATCH registers, TX/RX byte
// FIFOs and an 8N1 serializer/deserializer timed by a programmable divisor.
module io_uart_port
  import rcpu_io_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR   = 16'h0100,
  parameter int          FIFO_DEPTH  = 4,
  parameter logic [15:0] DEFAULT_DIV = 16'd104
) (
  input  logic          clk,
  input  logic          resetq,
  io_uart_port_if.slave io,
  input  logic          uart_rx,
  output logic          uart_tx
);
  logic [15:0] ofs;
  logic        hit, rd_data_sel, wr_data_sel, wr_status_sel, wr_baud_sel, wr_scratch_sel;
  logic [15:0] rd_val, status_val;
  logic [15:0] read_data_q, read_data_d;
  logic [15:0] baud_q, baud_d, scratch_q, scratch_d;
  logic        rxovr_q, rxovr_d, framerr_q, framerr_d, txdrop_q, txdrop_d;

  logic       tx_push, tx_pop, tx_full, tx_empty, tx_drop;
  logic [7:0] tx_dout;
  logic       rx_push, rx_pop, rx_full, rx_empty, rx_ovr_set, rx_ferr_set;
  logic [7:0] rx_dout;

  tx_state_e   tx_state_q, tx_state_d;
  logic [15:0] tx_cnt_q, tx_cnt_d;
  logic [7:0]  tx_shift_q, tx_shift_d;
  logic [2:0]  tx_idx_q, tx_idx_d;
  logic        tx_q, tx_d;

  rx_state_e   rx_state_q, rx_state_d;
  logic [15:0] rx_cnt_q, rx_cnt_d;
  logic [7:0]  rx_shift_q, rx_shift_d;
  logic [2:0]  rx_idx_q, rx_idx_d;
  logic        rx_s1_q, rx_s2_q, rx_prev_q, rx_fall;

  // Offset arithmetic keeps the decode correct for any base, aligned or not.
  assign ofs            = io.io_address - BASE_ADDR;
  assign hit            = (ofs < 16'd4);
  assign rd_data_sel    = io.io_read_enable  && hit && (ofs == OFS_DATA);
  assign wr_data_sel    = io.io_write_enable && hit && (ofs == OFS_DATA);
  assign wr_status_sel  = io.io_write_enable && hit && (ofs == OFS_STATUS);
  assign wr_baud_sel    = io.io_write_enable && hit && (ofs == OFS_BAUD);
  assign wr_scratch_sel = io.io_write_enable && hit && (ofs == OFS_SCRATCH);

  assign tx_push = wr_data_sel;
  assign tx_drop = wr_data_sel && tx_full && !tx_pop;
  assign rx_pop  = rd_data_sel && !rx_empty;

  io_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(clk), .rst_n(resetq), .push_i(tx_push), .data_i(io.io_write_data[7:0]),
    .pop_i(tx_pop), .data_o(tx_dout), .full_o(tx_full), .empty_o(tx_empty)
  );

  io_byte_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(clk), .rst_n(resetq), .push_i(rx_push), .data_i(rx_shift_q),
    .pop_i(rx_pop), .data_o(rx_dout), .full_o(rx_full), .empty_o(rx_empty)
  );

  assign status_val = (tx_full    ? ST_TX_FULL  : 16'h0) | (tx_empty  ? ST_TX_EMPTY : 16'h0) |
                      (rx_empty   ? ST_RX_EMPTY : 16'h0) | (rx_full   ? ST_RX_FULL  : 16'h0) |
                      (rxovr_q    ? ST_RXOVR    : 16'h0) | (framerr_q ? ST_FRAMERR  : 16'h0) |
                      (txdrop_q   ? ST_TXDROP   : 16'h0) |
                      ((tx_state_q != TX_IDLE) ? ST_TX_BUSY : 16'h0);

  always_comb begin
    rd_val = 16'h0;
    if (hit) begin
      case (ofs)
        OFS_DATA:    rd_val = rx_empty ? 16'h0 : {8'h00, rx_dout};
        OFS_STATUS:  rd_val = status_val;
        OFS_BAUD:    rd_val = baud_q;
        OFS_SCRATCH: rd_val = scratch_q;
        default:     rd_val = 16'h0;
      endcase
    end
    read_data_d = io.io_read_enable ? rd_val : read_data_q;
  end

  // Sticky flags: a set on the same edge as a write-1-to-clear wins.
  always_comb begin
    baud_d    = wr_baud_sel    ? clamp_baud(io.io_write_data) : baud_q;
    scratch_d = wr_scratch_sel ? io.io_write_data : scratch_q;
    rxovr_d   = (rxovr_q   && !(wr_status_sel && |(io.io_write_data & ST_RXOVR)))   || rx_ovr_set;
    framerr_d = (framerr_q && !(wr_status_sel && |(io.io_write_data & ST_FRAMERR))) || rx_ferr_set;
    txdrop_d  = (txdrop_q  && !(wr_status_sel && |(io.io_write_data & ST_TXDROP)))  || tx_drop;
  end

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_shift_d = tx_shift_q;
    tx_idx_d   = tx_idx_q;
    tx_pop     = 1'b0;
    case (tx_state_q)
      TX_IDLE: begin
        if (!tx_empty) begin
          tx_pop     = 1'b1;
          tx_shift_d = tx_dout;
          tx_cnt_d   = baud_q - 16'd1;
          tx_state_d = TX_START;
        end
      end
      TX_START: begin
        if (tx_cnt_q == 16'd0) begin
          tx_cnt_d   = baud_q - 16'd1;
          tx_idx_d   = 3'd0;
          tx_state_d = TX_DATA;
        end else tx_cnt_d = tx_cnt_q - 16'd1;
      end
      TX_DATA: begin
        if (tx_cnt_q == 16'd0) begin
          tx_cnt_d = baud_q - 16'd1;
          if (tx_idx_q == 3'd7) tx_state_d = TX_STOP;
          else begin
            tx_shift_d = tx_shift_q >> 1;
            tx_idx_d   = tx_idx_q + 3'd1;
          end
        end else tx_cnt_d = tx_cnt_q - 16'd1;
      end
      TX_STOP: begin
        if (tx_cnt_q == 16'd0) begin
          if (!tx_empty) begin
            tx_pop     = 1'b1;
            tx_shift_d = tx_dout;
            tx_cnt_d   = baud_q - 16'd1;
            tx_state_d = TX_START;
          end else tx_state_d = TX_IDLE;
        end else tx_cnt_d = tx_cnt_q - 16'd1;
      end
      default: tx_state_d = TX_IDLE;
    endcase
    // Line level is registered from the next state so it changes with the state.
    case (tx_state_d)
      TX_START: tx_d = 1'b0;
      TX_DATA:  tx_d = tx_shift_d[0];
      default:  tx_d = 1'b1;
    endcase
  end

  assign rx_fall = rx_prev_q && !rx_s2_q;

  always_comb begin
    rx_state_d  = rx_state_q;
    rx_cnt_d    = rx_cnt_q;
    rx_shift_d  = rx_shift_q;
    rx_idx_d    = rx_idx_q;
    rx_push     = 1'b0;
    rx_ovr_set  = 1'b0;
    rx_ferr_set = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (rx_fall) begin
          rx_cnt_d   = {1'b0, baud_q[15:1]} - 16'd1;
          rx_state_d = RX_START;
        end
      end
      RX_START: begin
        if (rx_cnt_q == 16'd0) begin
          if (rx_s2_q) rx_state_d = RX_IDLE;
          else begin
            rx_cnt_d   = baud_q - 16'd1;
            rx_idx_d   = 3'd0;
            rx_state_d = RX_DATA;
          end
        end else rx_cnt_d = rx_cnt_q - 16'd1;
      end
      RX_DATA: begin
        if (rx_cnt_q == 16'd0) begin
          rx_shift_d = {rx_s2_q, rx_shift_q[7:1]};
          rx_cnt_d   = baud_q - 16'd1;
          if (rx_idx_q == 3'd7) rx_state_d = RX_STOP;
          else rx_idx_d = rx_idx_q + 3'd1;
        end else rx_cnt_d = rx_cnt_q - 16'd1;
      end
      RX_STOP: begin
        if (rx_cnt_q == 16'd0) begin
          rx_state_d = RX_IDLE;
          if (!rx_s2_q)               rx_ferr_set = 1'b1;
          else if (rx_full && !rx_pop) rx_ovr_set  = 1'b1;
          else                         rx_push     = 1'b1;
        end else rx_cnt_d = rx_cnt_q - 16'd1;
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetq) begin
    if (!resetq) begin
      read_data_q <= 16'h0;
      baud_q      <= DEFAULT_DIV;
      scratch_q   <= 16'h0;
      rxovr_q     <= 1'b0;
      framerr_q   <= 1'b0;
      txdrop_q    <= 1'b0;
      tx_state_q  <= TX_IDLE;
      tx_cnt_q    <= 16'h0;
      tx_shift_q  <= 8'h0;
      tx_idx_q    <= 3'd0;
      tx_q        <= 1'b1;
      rx_state_q  <= RX_IDLE;
      rx_cnt_q    <= 16'h0;
      rx_shift_q  <= 8'h0;
      rx_idx_q    <= 3'd0;
      rx_s1_q     <= 1'b1;
      rx_s2_q     <= 1'b1;
      rx_prev_q   <= 1'b1;
    end else begin
      read_data_q <= read_data_d;
      baud_q      <= baud_d;
      scratch_q   <= scratch_d;
      rxovr_q     <= rxovr_d;
      framerr_q   <= framerr_d;
      txdrop_q    <= txdrop_d;
      tx_state_q  <= tx_state_d;
      tx_cnt_q    <= tx_cnt_d;
      tx_shift_q  <= tx_shift_d;
      tx_idx_q    <= tx_idx_d;
      tx_q        <= tx_d;
      rx_state_q  <= rx_state_d;
      rx_cnt_q    <= rx_cnt_d;
      rx_shift_q  <= rx_shift_d;
      rx_idx_q    <= rx_idx_d;
      rx_s1_q     <= uart_rx;
      rx_s2_q     <= rx_s1_q;
      rx_prev_q   <= rx_s2_q;
    end
  end

  assign io.io_read_data = read_data_q;
  assign io.dbg_tx_state = tx_state_q;
  assign io.dbg_rx_state = rx_state_q;
  assign uart_tx         = tx_q;
endmodule

// File: tb/tb_io_uart_port.sv
// Directed bench for io_uart_port: register access, TX frame shape, RX capture,
// FIFO full/drop/overrun, sticky clears and mid-frame reset.
module tb_io_uart_port;
  import rcpu_io_pkg::*;

  localparam logic [15:0] A_DATA    = 16'h0100;
  localparam logic [15:0] A_STATUS  = 16'h0101;
  localparam logic [15:0] A_BAUD    = 16'h0102;
  localparam logic [15:0] A_SCRATCH = 16'h0103;

  logic clk, resetq, uart_rx, uart_tx;
  int   total, bad;
  logic [15:0] rd;

  io_uart_port_if io_if ();

  io_uart_port dut (
    .clk(clk), .resetq(resetq), .io(io_if), .uart_rx(uart_rx), .uart_tx(uart_tx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // All bus tasks start and end on a falling edge.
  task automatic io_write(input logic [15:0] a, input logic [15:0] d);
    io_if.io_write_enable = 1'b1;
    io_if.io_address      = a;
    io_if.io_write_data   = d;
    @(negedge clk);
    io_if.io_write_enable = 1'b0;
  endtask

  task automatic io_read(input logic [15:0] a, output logic [15:0] d);
    io_if.io_read_enable = 1'b1;
    io_if.io_address     = a;
    @(negedge clk);
    io_if.io_read_enable = 1'b0;
    d = io_if.io_read_data;
  endtask

  task automatic io_rw(input logic [15:0] a, input logic [15:0] wd, output logic [15:0] d);
    io_if.io_read_enable  = 1'b1;
    io_if.io_write_enable = 1'b1;
    io_if.io_address      = a;
    io_if.io_write_data   = wd;
    @(negedge clk);
    io_if.io_read_enable  = 1'b0;
    io_if.io_write_enable = 1'b0;
    d = io_if.io_read_data;
  endtask

  // frame[k] is the k-th bit on the line (start first); every clock of every bit is checked.
  task automatic check_tx_frame(input string tag, input logic [9:0] frame, input int baud,
                                input bit chk_busy);
    int t;
    logic [15:0] st;
    for (t = 0; t < 400 && uart_tx !== 1'b0; t++) @(negedge clk);
    check({tag, "_start_timeout"}, (t >= 400) ? 16'd1 : 16'd0, 16'd0);
    for (int k = 0; k < 10 * baud; k++) begin
      check(tag, {15'b0, uart_tx}, {15'b0, frame[k / baud]});
      if (chk_busy && k == 2 * baud) begin
        io_if.io_read_enable = 1'b1;
        io_if.io_address     = A_STATUS;
      end
      if (chk_busy && k == 2 * baud + 1) begin
        io_if.io_read_enable = 1'b0;
        st = io_if.io_read_data;
        check({tag, "_status_busy"}, st, 16'h0086);
      end
      @(negedge clk);
    end
  endtask

  task automatic send_rx_frame(input logic [7:0] b, input logic stop, input int baud);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      uart_rx = f[i];
      repeat (baud) @(negedge clk);
    end
    uart_rx = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    resetq = 1'b0;
    uart_rx = 1'b1;
    io_if.io_read_enable  = 1'b0;
    io_if.io_write_enable = 1'b0;
    io_if.io_address      = 16'h0;
    io_if.io_write_data   = 16'h0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_read_data", io_if.io_read_data, 16'h0000);
    check("reset_uart_tx", {15'b0, uart_tx}, 16'h0001);
    @(negedge clk);
    resetq = 1'b1;
    @(negedge clk);

    // 1. Reset values
    io_read(A_STATUS, rd); check("reset_status", rd, 16'h0006);
    io_read(A_BAUD, rd);   check("reset_baud", rd, 16'd104);

    // BAUD clamp, SCRATCH storage, window misses
    io_write(A_BAUD, 16'h0001); io_read(A_BAUD, rd); check("baud_clamp_1", rd, 16'h0002);
    io_write(A_BAUD, 16'h0000); io_read(A_BAUD, rd); check("baud_clamp_0", rd, 16'h0002);
    io_write(A_SCRATCH, 16'hBEEF); io_read(A_SCRATCH, rd); check("scratch_rw", rd, 16'hBEEF);
    io_read(16'h0104, rd); check("miss_read_hi", rd, 16'h0000);
    io_read(A_SCRATCH, rd);
    io_read(16'h00FF, rd); check("miss_read_lo", rd, 16'h0000);
    io_write(16'h0104, 16'h1234); io_write(16'h00FF, 16'h5678);
    io_read(A_SCRATCH, rd); check("miss_write_ignored", rd, 16'hBEEF);
    io_read(A_DATA, rd); check("rx_empty_read", rd, 16'h0000);

    // 2. TX frame 0xA5 at BAUD=8
    io_write(A_BAUD, 16'd8); io_read(A_BAUD, rd); check("baud_8", rd, 16'd8);
    io_write(A_DATA, 16'h00A5);
    check_tx_frame("tx_a5", 10'b1101001010, 8, 1'b1);
    io_read(A_STATUS, rd); check("status_after_tx", rd, 16'h0006);

    // 3. RX frame 0x3C
    send_rx_frame(8'h3C, 1'b1, 8);
    io_read(A_DATA, rd);   check("rx_3c", rd, 16'h003C);
    io_read(A_DATA, rd);   check("rx_second_read", rd, 16'h0000);
    io_read(A_STATUS, rd); check("status_rx_empty", rd, 16'h0006);

    // 4. TX FIFO full and drop while a 0xFF frame is on the line
    io_write(A_DATA, 16'h00FF);
    for (int i = 1; i <= 5; i++) io_write(A_DATA, 16'h0020 + 16'(i));
    io_read(A_STATUS, rd); check("status_tx_full_drop", rd, 16'h00C5);
    repeat (10) @(negedge clk);
    check_tx_frame("tx_21", {1'b1, 8'h21, 1'b0}, 8, 1'b0);
    check_tx_frame("tx_22", {1'b1, 8'h22, 1'b0}, 8, 1'b0);
    check_tx_frame("tx_23", {1'b1, 8'h23, 1'b0}, 8, 1'b0);
    check_tx_frame("tx_24", {1'b1, 8'h24, 1'b0}, 8, 1'b0);
    io_read(A_STATUS, rd); check("status_after_burst", rd, 16'h0046);
    repeat (20) @(negedge clk);
    check("tx_idle_after_burst", {15'b0, uart_tx}, 16'h0001);
    io_write(A_STATUS, 16'd64);
    io_read(A_STATUS, rd); check("txdrop_cleared", rd, 16'h0006);

    // 5. Framing error, then overrun
    send_rx_frame(8'h55, 1'b0, 8);
    io_read(A_STATUS, rd); check("status_framerr", rd, 16'h0026);
    io_write(A_STATUS, 16'd32);
    io_read(A_STATUS, rd); check("framerr_cleared", rd, 16'h0006);
    send_rx_frame(8'h01, 1'b1, 8);
    send_rx_frame(8'h80, 1'b1, 8);
    send_rx_frame(8'hC3, 1'b1, 8);
    send_rx_frame(8'h7E, 1'b1, 8);
    send_rx_frame(8'h99, 1'b1, 8);
    io_read(A_STATUS, rd); check("status_rx_full_ovr", rd, 16'h001A);
    io_read(A_DATA, rd); check("rx_byte0", rd, 16'h0001);
    io_read(A_DATA, rd); check("rx_byte1", rd, 16'h0080);
    io_read(A_DATA, rd); check("rx_byte2", rd, 16'h00C3);
    io_read(A_DATA, rd); check("rx_byte3", rd, 16'h007E);
    io_read(A_STATUS, rd); check("status_rx_drained", rd, 16'h0016);

    // 6. Read+write STATUS in one cycle, then reset mid-frame
    io_rw(A_STATUS, 16'd16, rd); check("rw_status_pre_clear", rd, 16'h0016);
    io_read(A_STATUS, rd);       check("rw_status_post_clear", rd, 16'h0006);
    send_rx_frame(8'h5A, 1'b1, 8);
    io_read(A_STATUS, rd); check("status_rx_pending", rd, 16'h0002);
    io_write(A_DATA, 16'h0000);
    io_write(A_DATA, 16'h0000);
    io_write(A_DATA, 16'h0000);
    repeat (18) @(negedge clk);
    check("tx_low_mid_frame", {15'b0, uart_tx}, 16'h0000);
    resetq = 1'b0;
    #1;
    check("reset_tx_high_now", {15'b0, uart_tx}, 16'h0001);
    @(negedge clk);
    @(negedge clk);
    resetq = 1'b1;
    @(negedge clk);
    io_read(A_STATUS, rd); check("status_after_reset", rd, 16'h0006);
    io_read(A_BAUD, rd);   check("baud_after_reset", rd, 16'd104);
    io_read(A_DATA, rd);   check("rx_empty_after_reset", rd, 16'h0000);
    repeat (10) @(negedge clk);
    check("tx_idle_after_reset", {15'b0, uart_tx}, 16'h0001);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
